// File: rtl/demux_seq_pkg.sv
// Shared types and helpers for the round-robin demux sequencer.
// Holds the channel count, the select width and the wrap-around first-set search.
package demux_seq_pkg;

  localparam int NCH  = 8;
  localparam int SELW = 3;

  typedef enum logic {IDLE, XFER} state_e;

  // Returns {found, index} of the first set mask bit at or after start, wrapping.
  // Walking the offsets downward lets the smallest offset overwrite the result last.
  function automatic logic [SELW:0] rr_first_set(input logic [NCH-1:0]  mask,
                                                 input logic [SELW-1:0] start);
    logic [SELW:0]   res;
    logic [SELW-1:0] idx;
    res = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = start + SELW'(i);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/demux_seq_ctrl_rr_next_ch.sv
// Combinational wrap-around search for the next enabled channel.
// found is low only when mask is empty.
module rr_next_ch
  import demux_seq_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] start,
  output logic [SELW-1:0] next,
  output logic            found
);

  assign {found, next} = rr_first_set(mask, start);

endmodule

// File: rtl/demux_seq_ctrl.sv
// Round-robin burst sequencer steering one valid/ready stream to eight channels.
// Optional per-channel saturating beat counters are enabled by DEMUX_SEQ_STATS_EN.
module demux_seq_ctrl
  import demux_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en_mask,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [NCH-1:0]   out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic [NCH-1:0]   out_ready,
  output logic [SELW-1:0]  sel,
`ifdef DEMUX_SEQ_STATS_EN
  input  logic [SELW-1:0]  stat_ch,
  output logic [15:0]      stat_cnt,
`endif
  output logic             busy,
  output logic             burst_done
);

  localparam int              CNT_W    = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  state_e            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SELW-1:0]   search_start;
  logic [SELW-1:0]   nxt_ch;
  logic              nxt_found;
  logic              beat;

  // IDLE may re-grant the current channel; a turn ending in XFER searches past it.
  assign search_start = (state_q == XFER) ? sel_q + SELW'(1) : sel_q;

  rr_next_ch u_rr_next_ch (
    .mask  (en_mask),
    .start (search_start),
    .next  (nxt_ch),
    .found (nxt_found)
  );

  assign out_data = in_data;
  assign sel      = sel_q;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    out_valid  = '0;
    burst_done = 1'b0;
    busy       = 1'b0;
    beat       = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_mask != '0) begin
          state_d = XFER;
          sel_d   = nxt_ch;
          cnt_d   = '0;
        end
      end
      XFER: begin
        busy = 1'b1;
        if (en_mask[sel_q]) begin
          in_ready  = out_ready[sel_q];
          out_valid = in_valid ? ({{(NCH-1){1'b0}}, 1'b1} << sel_q) : '0;
          beat      = in_valid && out_ready[sel_q];
          if (beat) begin
            if (cnt_q == CNT_LAST) begin
              burst_done = 1'b1;
              cnt_d      = '0;
              if (nxt_found) sel_d = nxt_ch;
              else           state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end else begin
          // Channel dropped mid-turn: abandon the turn without a burst_done pulse.
          cnt_d = '0;
          if (nxt_found) sel_d = nxt_ch;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      in_ready   = 1'b0;
      out_valid  = '0;
      burst_done = 1'b0;
      busy       = 1'b0;
      beat       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DEMUX_SEQ_STATS_EN
  logic [15:0] stat_q [NCH];
  logic [15:0] stat_d [NCH];

  always_comb begin
    stat_d = stat_q;
    if (beat && (stat_q[sel_q] != 16'hFFFF)) stat_d[sel_q] = stat_q[sel_q] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) stat_q[i] <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt = stat_q[stat_ch];
`endif

endmodule

// File: doc/demux_seq_ctrl.md
# demux_seq_ctrl

Round-robin burst sequencer driving the 1-to-8 demultiplexer path. Accepts one valid/ready input stream and steers it to one of eight output channels. Each enabled channel receives BURST beats per turn, then the grant rotates to the next enabled channel. The block owns `sel[2:0]`, which feeds the demux select directly, and handles per-channel backpressure.

## Interface
Parameters:
- WIDTH, 8, data width of each beat.
- BURST, 4, beats per channel turn; legal range 1..256.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en_mask  in  8  channel enables; bit i enables channel i; sampled every cycle.
- in_valid  in  1  input beat present.
- in_data  in  WIDTH  input beat.
- in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
- out_valid  out  8  one-hot per-channel valid.
- out_data  out  WIDTH  shared output data, equal to in_data (zero-latency path).
- out_ready  in  8  per-channel ready.
- sel  out  3  current channel index, the demux select.
- busy  out  1  high in XFER.
- burst_done  out  1  one-cycle pulse on the last beat of a turn.

## Operation
- States: IDLE, XFER.
- Reset values: state=IDLE, sel=0, cnt=0, busy=0, burst_done=0, out_valid=0, in_ready=0.
- IDLE:
  - in_ready=0, out_valid=0, sel holds its value.
  - If en_mask≠0, move to XFER on the next edge.
  - The channel chosen is the first enabled index searching upward from sel inclusive, with wrap.
- XFER, combinational outputs:
  - out_valid = in_valid ? (8'b1 << sel) : 0.
  - in_ready = out_ready[sel].
  - Both outputs are forced to 0 if en_mask[sel]=0.
- Beat: in_valid & in_ready. On each beat cnt increments.
- End of turn, on the beat where cnt=BURST-1:
  - burst_done=1 and cnt←0.
  - sel moves to the first enabled index searching from sel+1 with wrap.
  - If sel is the only enabled channel, it is reselected.
  - If en_mask=0, go to IDLE.
- Channel disabled mid-burst, in XFER with en_mask[sel]=0:
  - No beat can occur (outputs are gated off).
  - The next edge sets cnt←0, rotates to the next enabled channel (search from sel+1), or goes to IDLE if the mask is empty.
  - burst_done is not asserted.
- Stalls (in_valid=0 or out_ready[sel]=0): state, sel and cnt hold. There is no timeout.
- en_mask changes take effect for the rotation decision in the same cycle they are presented.
- cnt width is clog2(BURST), minimum 1 bit.

## Timing
- Data path latency is 0 cycles; there is no registering between in_* and out_*.
- IDLE to first acceptable beat: 1 cycle after en_mask becomes nonzero.
- Rotation costs 0 bubble cycles: the beat after the last beat of a turn can go to the new channel on the immediately following cycle.
- burst_done is combinational with the final beat. It is high only in that cycle.
- Reset asserted mid-burst: on the next edge all state returns to reset values. The in-flight beat in that cycle is not counted. Outputs are reset values while rst=1.
- sel is registered and changes only on clock edges.

## Configuration
- Macro DEMUX_SEQ_STATS_EN.
- Defined:
  - Adds input `stat_ch[2:0]` and output `stat_cnt[15:0]`.
  - Each channel has a 16-bit saturating beat counter, incremented on beats to that channel, held at 16'hFFFF once reached, cleared by rst.
  - stat_cnt is a combinational read of counter stat_ch.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `demux_seq_pkg`:
  - NCH=8 and SELW=3.
  - State enum {IDLE, XFER}.
  - Function for the wrap-around first-set search.
- One sub-module, `rr_next_ch`:
  - Combinational.
  - Inputs: mask[7:0], start[2:0].
  - Outputs: next[2:0], found.
  - Instantiated once for the rotation search.
  - The IDLE search reuses it with start=sel. The XFER search uses start=sel+1.

## Test plan
- Reset then rotation: rst 2 cycles → out_valid=0, in_ready=0, sel=0, busy=0. Then en_mask=8'hFF, constant valid, all ready, BURST=4 → sel sequence 0,0,0,0,1,1,1,1,…,7 then wraps to 0. burst_done every 4th beat; no bubbles.
- Sparse mask: en_mask=8'b1000_0100, starting at sel=0 → grants go to 2 then 7 then 2, 4 beats each. Channels 0,1,3-6 never see out_valid.
- Backpressure: out_ready[sel]=0 for 3 cycles mid-burst at cnt=2 → in_ready=0, sel and cnt hold. Resume → exactly 2 more beats before rotation.
- Mid-burst disable: on channel 3 at cnt=1, clear en_mask[3] → out_valid=0 that cycle, no burst_done. Next cycle sel=4 (enabled), cnt=0. en_mask=0 → IDLE.
- Single channel plus reset mid-op: en_mask=8'h20 → sel stays 5 across bursts, burst_done every 4 beats. Assert rst at cnt=2 → all outputs at reset values next cycle, with sel=0.
- With DEMUX_SEQ_STATS_EN: 10 beats to ch1 → stat_ch=1 gives stat_cnt=10. Force 70000 beats to ch0 → stat_cnt=16'hFFFF.
